// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed display scanner with per-slot latching, guard blanking, PWM dimming and blink.
module display_scanner #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [8*DIGITS-1:0]   segs,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     SD,
  output logic [7:0]            SEG,
  output logic                  frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p;
  logic [DW-1:0] d;
  logic [3:0]    pwm;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic [7:0]    seg_l;
  logic          en_l;
  logic          blink_l;

  logic [7:0]    seg_arr [DIGITS];
  logic [7:0]    cur_seg;
  logic          cur_en;
  logic          cur_blink;
  logic          drive;
  logic [DIGITS-1:0] sd_onehot;
  logic          p_wrap;

  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign seg_arr[k] = segs[8*k +: 8];
  end

  assign p_wrap = (p == P_LAST);

  // At p==0 the slot register is still loading, so the live inputs stand in for it.
  always_comb begin
    cur_seg   = seg_l;
    cur_en    = en_l;
    cur_blink = blink_l;
    if (p == '0) begin
      cur_seg   = seg_arr[d];
      cur_en    = en_mask[d];
      cur_blink = blink_mask[d];
    end
    drive = (p >= P_GUARD) && cur_en && !(cur_blink && blink_phase) &&
            ((bright == 4'hF) || (pwm < bright));
    sd_onehot    = '0;
    sd_onehot[d] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      p           <= '0;
      d           <= '0;
      pwm         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_l       <= '0;
      en_l        <= 1'b0;
      blink_l     <= 1'b0;
      SD          <= '0;
      SEG         <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      if (p_wrap) begin
        p   <= '0;
        pwm <= '0;
        if (d == D_LAST) begin
          d <= '0;
          if (frame_cnt == F_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end else begin
          d <= d + DW'(1);
        end
      end else begin
        p   <= p + PW'(1);
        pwm <= pwm + 4'd1;
      end

      if (p == '0) begin
        seg_l   <= cur_seg;
        en_l    <= cur_en;
        blink_l <= cur_blink;
      end

      SD          <= drive ? sd_onehot : '0;
      SEG         <= drive ? cur_seg : 8'h00;
      frame_start <= (p == '0) && (d == '0);
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized self-checking bench for display_scanner against a cycle-count reference model.
module tb_display_scanner;
  localparam int DIGITS = 4;
  localparam int DIV    = 40;
  localparam int GUARD  = 4;
  localparam int BF     = 2;
  localparam int FRAME  = DIV * DIGITS;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] segs = 32'h11223344;
  logic [3:0]  en_mask = 4'hF;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  SD;
  logic [7:0]  SEG;
  logic        frame_start;

  always #5 Clock = ~Clock;

  display_scanner #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
    .Clock(Clock), .Reset(Reset), .segs(segs), .en_mask(en_mask),
    .blink_mask(blink_mask), .bright(bright), .SD(SD), .SEG(SEG), .frame_start(frame_start)
  );

  int checks = 0;
  int passes = 0;
  int n = 0;
  logic [7:0]  m_seg;
  logic        m_en, m_blink;
  logic [12:0] exp_v;

  // Model: position in the scan follows purely from cycles since reset release.
  task automatic step();
    int p, d, f;
    bit drv;
    p = n % DIV;
    d = (n / DIV) % DIGITS;
    f = n / FRAME;
    if (p == 0) begin
      m_seg = segs[8*d +: 8];
      m_en = en_mask[d];
      m_blink = blink_mask[d];
    end
    drv = (p >= GUARD) && m_en && !(m_blink && ((f / BF) % 2 == 1)) &&
          ((bright == 4'hF) || ((p % 16) < int'(bright)));
    exp_v = drv ? {4'(1 << d), m_seg, 1'b0} : 13'h0;
    exp_v[0] = (p == 0) && (d == 0);
    @(posedge Clock); #1;
    n++;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      segs = $urandom; en_mask = 4'($urandom); bright = 4'($urandom);
      @(posedge Clock); #1;
      checks++;
      if ({SD, SEG, frame_start} !== 13'h0) $display("FAIL reset_state got %h want 0", {SD, SEG, frame_start});
      else passes++;
    end
    Reset = 1'b0;
    n = 0;
  endtask

  task automatic test_basic();
    int first_on, cnt0, fs1, fs2;
    segs = 32'h11223344; en_mask = 4'hF; blink_mask = 4'h0; bright = 4'hF;
    apply_reset();
    first_on = -1; cnt0 = 0; fs1 = -1; fs2 = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL basic n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (first_on < 0 && SD != 0) first_on = n;
      if (n <= DIV && SD == 4'b0001 && SEG == 8'h44) cnt0++;
      if (frame_start) begin
        if (fs1 < 0) fs1 = n; else if (fs2 < 0) fs2 = n;
      end
    end
    checks++;
    if (first_on !== 5) $display("FAIL basic_first_on got %0d want 5", first_on); else passes++;
    checks++;
    if (cnt0 !== 36) $display("FAIL basic_digit0_len got %0d want 36", cnt0); else passes++;
    checks++;
    if (fs2 - fs1 !== 160) $display("FAIL basic_frame_period got %0d want 160", fs2 - fs1); else passes++;
  endtask

  task automatic test_pwm();
    int on_cnt, on_zero;
    segs = 32'h11223344; en_mask = 4'hF; blink_mask = 4'h0; bright = 4'd4;
    apply_reset();
    on_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL pwm4 n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (SD != 0) on_cnt++;
    end
    checks++;
    if (on_cnt !== 32) $display("FAIL pwm4_on_cycles got %0d want 32", on_cnt); else passes++;
    bright = 4'd0;
    on_zero = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL pwm0 n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (i > 0 && SD != 0) on_zero++;
    end
    checks++;
    if (on_zero !== 0) $display("FAIL pwm0_dark got %0d want 0", on_zero); else passes++;
  endtask

  task automatic test_enable();
    int bad, c1, c3;
    segs = 32'h11223344; en_mask = 4'b1010; blink_mask = 4'h0; bright = 4'hF;
    apply_reset();
    bad = 0; c1 = 0; c3 = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL enable n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (SD == 4'b0001 || SD == 4'b0100) bad++;
      if (SD == 4'b0010 && n >= 45 && n <= 80) c1++;
      if (SD == 4'b1000 && n >= 125 && n <= 160) c3++;
    end
    checks++;
    if (bad !== 0) $display("FAIL enable_masked got %0d want 0", bad); else passes++;
    checks++;
    if (c1 !== 36 || c3 !== 36) $display("FAIL enable_timing got %0d/%0d want 36/36", c1, c3); else passes++;
  endtask

  task automatic test_blink();
    int cnt [6];
    int want [6];
    want = '{36, 36, 0, 0, 36, 36};
    cnt = '{0, 0, 0, 0, 0, 0};
    segs = 32'h11223344; en_mask = 4'hF; blink_mask = 4'b0001; bright = 4'hF;
    apply_reset();
    for (int i = 0; i < 6 * FRAME; i++) begin
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL blink n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (SD == 4'b0001) cnt[(n - 1) / FRAME]++;
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cnt[f] !== want[f]) $display("FAIL blink_frame%0d got %0d want %0d", f, cnt[f], want[f]);
      else passes++;
    end
  endtask

  task automatic test_midslot_change();
    int old_bad, new_ok;
    segs = 32'h11223344; en_mask = 4'hF; blink_mask = 4'h0; bright = 4'hF;
    apply_reset();
    old_bad = 0; new_ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (n == 10) segs[7:0] = 8'hFF;
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL midslot n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (n <= FRAME && SD == 4'b0001 && SEG != 8'h44) old_bad++;
      if (n > FRAME && SD == 4'b0001 && SEG == 8'hFF) new_ok++;
    end
    checks++;
    if (old_bad !== 0) $display("FAIL midslot_hold got %0d want 0", old_bad); else passes++;
    checks++;
    if (new_ok !== 36) $display("FAIL midslot_update got %0d want 36", new_ok); else passes++;
  endtask

  task automatic test_reset_midslot();
    int first_on;
    segs = 32'h11223344; en_mask = 4'hF; blink_mask = 4'h0; bright = 4'hF;
    apply_reset();
    while (n < 2 * DIV + 20) step();
    checks++;
    if (SD !== 4'b0100) $display("FAIL rst_mid_pre got %b want 0100", SD); else passes++;
    Reset = 1'b1;
    @(posedge Clock); #1;
    checks++;
    if ({SD, SEG, frame_start} !== 13'h0) $display("FAIL rst_mid_abort got %h want 0", {SD, SEG, frame_start});
    else passes++;
    Reset = 1'b0;
    n = 0;
    first_on = -1;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL rst_mid_restart n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
      if (first_on < 0 && SD != 0) first_on = n;
    end
    checks++;
    if (first_on !== GUARD + 1) $display("FAIL rst_mid_guard got %0d want %0d", first_on, GUARD + 1); else passes++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        segs = $urandom;
        en_mask = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) bright = 4'($urandom);
      step();
      checks++;
      if ({SD, SEG, frame_start} !== exp_v) $display("FAIL random n=%0d got %h want %h", n, {SD, SEG, frame_start}, exp_v);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pwm();
    test_enable();
    test_blink();
    test_midslot_change();
    test_reset_midslot();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
